// File: rtl/seq_mul_div_pkg.sv
// Shared op codes and helpers for the iterative multiply/divide unit.
// Op codes sit alongside the ALU op codes used by the execute stage.
package seq_mul_div_pkg;

    localparam int MDU_OP_BIT = 3;

    localparam logic [MDU_OP_BIT-1:0] MDU_OP_MULT  = 3'd0;
    localparam logic [MDU_OP_BIT-1:0] MDU_OP_MULTU = 3'd1;
    localparam logic [MDU_OP_BIT-1:0] MDU_OP_DIV   = 3'd2;
    localparam logic [MDU_OP_BIT-1:0] MDU_OP_DIVU  = 3'd3;
    localparam logic [MDU_OP_BIT-1:0] MDU_OP_MTHI  = 3'd4;
    localparam logic [MDU_OP_BIT-1:0] MDU_OP_MTLO  = 3'd5;

    // Magnitude of a 32-bit operand; the most negative value maps onto itself,
    // which the unsigned datapath reads as the correct magnitude 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/seq_mul_div_mdu_step.sv
// One combinational iteration on the partial {acc, operand} register:
// LSB-first shift-add for multiply, MSB-first restoring shift-subtract for divide.
module seq_mul_div_mdu_step #(
    parameter bit IS_DIV = 1'b0
) (
    input  logic [31:0] acc_in,
    input  logic [31:0] opd_in,
    input  logic [31:0] arg,
    output logic [31:0] acc_out,
    output logic [31:0] opd_out
);

    if (IS_DIV) begin : g_div
        logic [32:0] shifted;
        logic        fits;

        // The remainder always stays below the divisor, so the 32-bit wrapped
        // difference is exact whenever the subtraction is taken.
        assign shifted = {acc_in, opd_in[31]};
        assign fits    = (shifted >= {1'b0, arg});
        assign acc_out = fits ? (shifted[31:0] - arg) : shifted[31:0];
        assign opd_out = {opd_in[30:0], fits};
    end else begin : g_mul
        logic [32:0] sum;

        assign sum     = {1'b0, acc_in} + (opd_in[0] ? {1'b0, arg} : 33'd0);
        assign acc_out = sum[32:1];
        assign opd_out = {sum[0], opd_in[31:1]};
    end

endmodule

// File: rtl/seq_mul_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Magnitudes are iterated unsigned; sign correction happens in a single FIX cycle.
module seq_mul_div
    import seq_mul_div_pkg::*;
#(
    parameter int STEP_BITS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [MDU_OP_BIT-1:0] op,
    input  logic [31:0]           data_x,
    input  logic [31:0]           data_y,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           hi,
    output logic [31:0]           lo
);

    localparam int N_ITER = 32 / STEP_BITS;
    localparam int CNT_W  = $clog2(N_ITER) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

    state_e             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        acc_q, opd_q, arg_q, x_orig_q;
    logic               is_div_q, neg_q, rem_neg_q, div0_q;

    logic               is_signed, is_div_op, is_md, last_iter;
    logic [31:0]        step_acc, step_opd;
    logic [63:0]        prod_fix;
    logic [31:0]        quot_fix, rem_fix, fix_hi, fix_lo;

    assign is_signed = (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
    assign is_div_op = (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    assign is_md     = is_div_op || (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
    assign last_iter = (cnt == CNT_W'(N_ITER - 1));
    assign busy      = (state != S_IDLE);

    for (genvar i = 0; i < STEP_BITS; i++) begin : g_mul
        logic [31:0] acc_i, opd_i, acc_o, opd_o;
        if (i == 0) begin : g_head
            assign acc_i = acc_q;
            assign opd_i = opd_q;
        end else begin : g_link
            assign acc_i = g_mul[i-1].acc_o;
            assign opd_i = g_mul[i-1].opd_o;
        end
        seq_mul_div_mdu_step #(.IS_DIV(1'b0)) u_step (
            .acc_in (acc_i),
            .opd_in (opd_i),
            .arg    (arg_q),
            .acc_out(acc_o),
            .opd_out(opd_o)
        );
    end

    for (genvar i = 0; i < STEP_BITS; i++) begin : g_div
        logic [31:0] acc_i, opd_i, acc_o, opd_o;
        if (i == 0) begin : g_head
            assign acc_i = acc_q;
            assign opd_i = opd_q;
        end else begin : g_link
            assign acc_i = g_div[i-1].acc_o;
            assign opd_i = g_div[i-1].opd_o;
        end
        seq_mul_div_mdu_step #(.IS_DIV(1'b1)) u_step (
            .acc_in (acc_i),
            .opd_in (opd_i),
            .arg    (arg_q),
            .acc_out(acc_o),
            .opd_out(opd_o)
        );
    end

    assign step_acc = is_div_q ? g_div[STEP_BITS-1].acc_o : g_mul[STEP_BITS-1].acc_o;
    assign step_opd = is_div_q ? g_div[STEP_BITS-1].opd_o : g_mul[STEP_BITS-1].opd_o;

    // Sign correction and the divide-by-zero override feeding the HI/LO write.
    always_comb begin
        prod_fix = neg_q ? (~{acc_q, opd_q} + 64'd1) : {acc_q, opd_q};
        quot_fix = neg_q ? (~opd_q + 32'd1) : opd_q;
        rem_fix  = rem_neg_q ? (~acc_q + 32'd1) : acc_q;
        fix_hi   = prod_fix[63:32];
        fix_lo   = prod_fix[31:0];
        if (is_div_q) begin
            fix_hi = div0_q ? x_orig_q : rem_fix;
            fix_lo = div0_q ? 32'hFFFF_FFFF : quot_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (start && !flush && is_md) state_next = S_RUN;
            S_RUN:   if (flush) state_next = S_IDLE;
                     else if (last_iter) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Flush blocks every write so an aborted op leaves HI/LO untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc_q     <= '0;
            opd_q     <= '0;
            arg_q     <= '0;
            x_orig_q  <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: if (start && !flush) begin
                    if (op == MDU_OP_MTHI) begin
                        hi   <= data_x;
                        done <= 1'b1;
                    end else if (op == MDU_OP_MTLO) begin
                        lo   <= data_x;
                        done <= 1'b1;
                    end else if (is_md) begin
                        cnt       <= '0;
                        acc_q     <= '0;
                        opd_q     <= abs32(data_x, is_signed);
                        arg_q     <= abs32(data_y, is_signed);
                        x_orig_q  <= data_x;
                        is_div_q  <= is_div_op;
                        neg_q     <= is_signed && (data_x[31] ^ data_y[31]);
                        rem_neg_q <= is_signed && data_x[31];
                        div0_q    <= (data_y == 32'd0);
                    end
                end
                S_RUN: if (!flush) begin
                    acc_q <= step_acc;
                    opd_q <= step_opd;
                    cnt   <= cnt + CNT_W'(1);
                end
                S_FIX: if (!flush) begin
                    hi   <= fix_hi;
                    lo   <= fix_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_div.sv
// Directed bench for seq_mul_div: a vector table for single operations plus
// hand-written flush, reset, start-while-busy, back-to-back and STEP_BITS=2 cases.
module tb_seq_mul_div;
    import seq_mul_div_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  flush = 1'b0;
    logic [MDU_OP_BIT-1:0] op = '0;
    logic [31:0]           data_x = '0, data_y = '0;
    logic                  busy, done;
    logic [31:0]           hi, lo;

    logic                  start2 = 1'b0;
    logic                  flush2 = 1'b0;
    logic [MDU_OP_BIT-1:0] op2 = '0;
    logic [31:0]           data_x2 = '0, data_y2 = '0;
    logic                  busy2, done2;
    logic [31:0]           hi2, lo2;

    int errors = 0;
    int checks = 0;

    seq_mul_div #(.STEP_BITS(1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .data_x(data_x), .data_y(data_y),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    seq_mul_div #(.STEP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .op(op2), .data_x(data_x2), .data_y(data_y2),
        .flush(flush2), .busy(busy2), .done(done2), .hi(hi2), .lo(lo2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MDU_OP_BIT-1:0] op;
        logic [31:0]           x;
        logic [31:0]           y;
        logic [31:0]           hi;
        logic [31:0]           lo;
        int                    lat;
        string                 name;
    } vec_t;

    vec_t vecs [14];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Presents one request so that it is sampled at the next rising edge (E0).
    task automatic applyStimulus(input logic [MDU_OP_BIT-1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; data_x = x; data_y = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts rising edges since E0 until done is seen; bounded.
    task automatic waitDone(input int first, output int lat);
        lat = first;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic runWide(input logic [MDU_OP_BIT-1:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
        @(negedge clk);
        op2 = o; data_x2 = x; data_y2 = y; start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    initial begin
        int lat;
        int done_seen;

        vecs[0]  = '{MDU_OP_MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mult_m1x2"};
        vecs[1]  = '{MDU_OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 34, "multu_ffx2"};
        vecs[2]  = '{MDU_OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, "div_m7d2"};
        vecs[3]  = '{MDU_OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34, "div_7dm2"};
        vecs[4]  = '{MDU_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34, "div_min_m1"};
        vecs[5]  = '{MDU_OP_DIVU,  32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF, 34, "divu_7d0"};
        vecs[6]  = '{MDU_OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 34, "div_m5d0"};
        vecs[7]  = '{MDU_OP_MTHI,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1,  "mthi"};
        vecs[8]  = '{MDU_OP_MTLO,  32'h0000_ABCD, 32'd0,         32'h1234_5678, 32'h0000_ABCD, 1,  "mtlo"};
        vecs[9]  = '{MDU_OP_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_000C, 34, "mult_m3xm4"};
        vecs[10] = '{MDU_OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 34, "divu_100d7"};
        vecs[11] = '{MDU_OP_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, 34, "div_m8dm3"};
        vecs[12] = '{MDU_OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 34, "multu_2p32"};
        vecs[13] = '{MDU_OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 34, "mult_max_min"};

        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_lo_w2", lo2, 32'd0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].op, vecs[i].x, vecs[i].y);
            checkOutput($sformatf("%s_busy_e0", vecs[i].name), {31'd0, busy}, 32'(vecs[i].lat > 1));
            waitDone(1, lat);
            checkOutput($sformatf("%s_latency", vecs[i].name), 32'(lat), 32'(vecs[i].lat));
            checkOutput($sformatf("%s_busy_done", vecs[i].name), {31'd0, busy}, 32'd0);
            checkOutput($sformatf("%s_hi", vecs[i].name), hi, vecs[i].hi);
            checkOutput($sformatf("%s_lo", vecs[i].name), lo, vecs[i].lo);
        end

        // Flush at the tenth RUN cycle: no done, LO keeps the MTLO value.
        applyStimulus(MDU_OP_MTLO, 32'd5, 32'd0);
        waitDone(1, lat);
        checkOutput("flush_pre_lo", lo, 32'd5);
        applyStimulus(MDU_OP_MULT, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        checkOutput("flush_busy", {31'd0, busy}, 32'd0);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done) done_seen++;
        end
        checkOutput("flush_no_done", 32'(done_seen), 32'd0);
        checkOutput("flush_lo", lo, 32'd5);
        applyStimulus(MDU_OP_MULT, 32'd3, 32'd4);
        waitDone(1, lat);
        checkOutput("post_flush_latency", 32'(lat), 32'd34);
        checkOutput("post_flush_lo", lo, 32'd12);
        checkOutput("post_flush_hi", hi, 32'd0);

        // Reset in the middle of a DIVU clears HI/LO and busy.
        applyStimulus(MDU_OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        waitDone(1, lat);
        applyStimulus(MDU_OP_DIVU, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("midrst_hi", hi, 32'd0);
        checkOutput("midrst_lo", lo, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);

        // Start pulses during RUN must not disturb the op in flight.
        applyStimulus(MDU_OP_MULTU, 32'd5, 32'd6);
        lat = 1;
        @(negedge clk);
        op = MDU_OP_DIV; data_x = 32'd9; data_y = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 lat++;
        @(negedge clk);
        op = MDU_OP_MTHI; data_x = 32'hFFFF_1111; start = 1'b1;
        @(posedge clk);
        #1 begin lat++; start = 1'b0; end
        waitDone(lat, lat);
        checkOutput("busy_start_latency", 32'(lat), 32'd34);
        checkOutput("busy_start_hi", hi, 32'd0);
        checkOutput("busy_start_lo", lo, 32'd30);

        // Back-to-back: second start presented during the done cycle.
        applyStimulus(MDU_OP_MULTU, 32'd7, 32'd6);
        waitDone(1, lat);
        checkOutput("b2b_first_lo", lo, 32'd42);
        op = MDU_OP_DIVU; data_x = 32'd42; data_y = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(1, lat);
        checkOutput("b2b_second_latency", 32'(lat), 32'd34);
        checkOutput("b2b_second_lo", lo, 32'd8);
        checkOutput("b2b_second_hi", hi, 32'd2);

        // Two bits per cycle.
        runWide(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        checkOutput("w2_multu_latency", 32'(lat), 32'd18);
        checkOutput("w2_multu_hi", hi2, 32'hFFFF_FFFE);
        checkOutput("w2_multu_lo", lo2, 32'h0000_0001);
        runWide(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, lat);
        checkOutput("w2_div_latency", 32'(lat), 32'd18);
        checkOutput("w2_div_hi", hi2, 32'hFFFF_FFFF);
        checkOutput("w2_div_lo", lo2, 32'hFFFF_FFFD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
